// File: rtl/alu_protocol_checker_pkg.sv
// alu_chk_pkg: types and helpers shared by the ALU protocol checker files.
//   chk_id_e     - check identifiers, also their bit positions in the violation vectors
//   to_state_e   - states of the split-operand timeout FSM
//   exp_stage_t  - one stage of the expectation pipeline
//   CMD_CMP      - ALU compare command (arithmetic mode)
//   is_two_op()  - true when a mode/cmd pair consumes both operands
package alu_chk_pkg;

  typedef enum logic [1:0] {
    CHK_INVALID = 2'd0,
    CHK_TIMEOUT = 2'd1,
    CHK_CMPFLAG = 2'd2,
    CHK_HOLD    = 2'd3
  } chk_id_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } to_state_e;

  localparam logic [3:0] CMD_CMP = 4'd8;

  // from_to marks an expected error that came from the timeout, so that a
  // timeout coinciding with inp_valid=00 is reported once, as the timeout.
  typedef struct packed {
    logic valid;
    logic exp_err;
    logic from_to;
    logic is_cmp;
    logic ce;
  } exp_stage_t;

  function automatic logic is_two_op(input logic mode, input logic [31:0] cmd);
    if (mode) return cmd inside {32'd0, 32'd1, 32'd2, 32'd3, 32'd8, 32'd9, 32'd10};
    else      return cmd inside {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd12, 32'd13};
  endfunction

endpackage

// File: rtl/alu_protocol_checker_if.sv
// alu_protocol_checker_if: ALU operand/command bus plus result and flags.
//   inp_valid {b,a} operand valids, mode, cmd, ce  - ALU inputs
//   res (DW+1 bits), err, oflow, cout, g, l, e     - ALU outputs
//   master : drives everything (the ALU environment)
//   slave  : observes everything (the checker)
interface alu_protocol_checker_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic [1:0]    inp_valid;
  logic          mode;
  logic [CW-1:0] cmd;
  logic          ce;
  logic [DW:0]   res;
  logic          err;
  logic          oflow;
  logic          cout;
  logic          g;
  logic          l;
  logic          e;

  modport master (output inp_valid, mode, cmd, ce, res, err, oflow, cout, g, l, e);
  modport slave  (input  inp_valid, mode, cmd, ce, res, err, oflow, cout, g, l, e);
endinterface

// File: rtl/alu_protocol_checker_timeout.sv
// alu_chk_timeout: watches for a two-operand command that arrives with only
// one operand valid and strobes exp_to when the other operand has not shown
// up within TIMEOUT ce-qualified cycles.
//   clk, rst (async, active-low)
//   ce, mode, cmd, inp_valid - ALU input bus
//   exp_to                   - one-cycle strobe: ALU must raise err LAT cycles later
module alu_chk_timeout
  import alu_chk_pkg::*;
#(
  parameter int CW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          mode,
  input  logic [CW-1:0] cmd,
  input  logic [1:0]    inp_valid,
  output logic          exp_to
);

  localparam int CTW = $clog2(TIMEOUT + 1);

  to_state_e      state, state_nx;
  logic [CTW-1:0] cnt, cnt_nx;
  logic [1:0]     lat_valid, lat_valid_nx;
  logic           lat_mode, lat_mode_nx;
  logic [CW-1:0]  lat_cmd, lat_cmd_nx;

  logic partial, two_op, done, changed, expired;

  assign partial = (inp_valid == 2'b01) || (inp_valid == 2'b10);
  assign two_op  = is_two_op(mode, 32'(cmd));
  // lat_valid holds the one bit that was present, so any other bit is the missing operand
  assign done    = |(inp_valid & ~lat_valid);
  assign changed = (mode != lat_mode) || (cmd != lat_cmd);
  assign expired = (state == WAIT) && (cnt == CTW'(TIMEOUT));

  // State register with the latched window context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_valid <= '0;
      lat_mode  <= 1'b0;
      lat_cmd   <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lat_valid <= lat_valid_nx;
      lat_mode  <= lat_mode_nx;
      lat_cmd   <= lat_cmd_nx;
    end
  end

  // Next state; ce=0 freezes everything. An expired window wins over a
  // late-arriving operand in the same cycle.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lat_valid_nx = lat_valid;
    lat_mode_nx  = lat_mode;
    lat_cmd_nx   = lat_cmd;
    if (ce) begin
      case (state)
        IDLE: begin
          if (two_op && partial) begin
            state_nx     = WAIT;
            cnt_nx       = CTW'(1);
            lat_valid_nx = inp_valid;
            lat_mode_nx  = mode;
            lat_cmd_nx   = cmd;
          end
        end
        WAIT: begin
          if (expired || done) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (changed) begin
            if (two_op && partial) begin
              cnt_nx       = CTW'(1);
              lat_valid_nx = inp_valid;
              lat_mode_nx  = mode;
              lat_cmd_nx   = cmd;
            end else begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end
          end else begin
            cnt_nx = cnt + CTW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output: strobe on the cycle the window expires
  always_comb begin
    exp_to = 1'b0;
    if (ce && expired) exp_to = 1'b1;
  end

endmodule

// File: rtl/alu_protocol_checker.sv
// alu_protocol_checker: monitors the ALU bus and its outputs LAT cycles later.
//   clk, rst (async, active-low), en (record violations), clr (sync clear)
//   bus         - ALU bus, slave modport
//   viol_pulse  - per-check violations this cycle {hold, cmpflag, timeout, invalid}
//   viol_sticky - latched violations
//   viol_cnt    - saturating total count
//   first_id / first_valid - first violation since reset or clr (lowest ID wins ties)
module alu_protocol_checker
  import alu_chk_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int LAT     = 1,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  alu_protocol_checker_if.slave bus,
  output logic [3:0]            viol_pulse,
  output logic [3:0]            viol_sticky,
  output logic [CNTW-1:0]       viol_cnt,
  output logic [1:0]            first_id,
  output logic                  first_valid
);

  exp_stage_t      pipe [LAT];
  exp_stage_t      stage_in;
  exp_stage_t      tail;
  logic            exp_to;
  logic [DW:0]     res_q;
  logic [3:0]      raw;
  logic            flags_onehot;
  logic [2:0]      pcnt;
  logic [CNTW+2:0] cnt_sum;
  chk_id_e         low_id;

  alu_chk_timeout #(.CW(CW), .TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .ce        (bus.ce),
    .mode      (bus.mode),
    .cmd       (bus.cmd),
    .inp_valid (bus.inp_valid),
    .exp_to    (exp_to)
  );

  // What the ALU outputs must look like LAT cycles from now
  always_comb begin
    stage_in         = '0;
    stage_in.valid   = 1'b1;
    stage_in.from_to = exp_to;
    stage_in.exp_err = exp_to || (bus.ce && (bus.inp_valid == 2'b00));
    stage_in.is_cmp  = bus.ce && bus.mode && (bus.cmd == CW'(CMD_CMP));
    stage_in.ce      = bus.ce;
  end

  // Expectation pipeline; valid bits stay 0 for LAT cycles after reset.
  // res_q is the previous-cycle result used by the hold check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      res_q <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      res_q <= bus.res;
    end
  end

  assign tail = pipe[LAT-1];

  // The four checks, evaluated against the aligned pipeline tail
  always_comb begin
    raw          = '0;
    flags_onehot = ({bus.g, bus.l, bus.e} == 3'b001) ||
                   ({bus.g, bus.l, bus.e} == 3'b010) ||
                   ({bus.g, bus.l, bus.e} == 3'b100);
    if (tail.valid && !bus.err) begin
      raw[CHK_INVALID] = tail.exp_err && !tail.from_to;
      raw[CHK_TIMEOUT] = tail.exp_err && tail.from_to;
      raw[CHK_CMPFLAG] = tail.is_cmp && !flags_onehot;
    end
    raw[CHK_HOLD] = tail.valid && !tail.ce && (bus.res != res_q);
  end

  assign viol_pulse = en ? raw : 4'b0000;

  // Pulse population count and lowest-ID selection for the reporting registers
  always_comb begin
    pcnt    = 3'(viol_pulse[0]) + 3'(viol_pulse[1]) + 3'(viol_pulse[2]) + 3'(viol_pulse[3]);
    cnt_sum = (CNTW+3)'(viol_cnt) + (CNTW+3)'(pcnt);
    if (viol_pulse[0])      low_id = CHK_INVALID;
    else if (viol_pulse[1]) low_id = CHK_TIMEOUT;
    else if (viol_pulse[2]) low_id = CHK_CMPFLAG;
    else                    low_id = CHK_HOLD;
  end

  // Reporting registers; clr takes precedence, dropping any same-cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol_sticky <= '0;
      viol_cnt    <= '0;
      first_id    <= '0;
      first_valid <= 1'b0;
    end else if (clr) begin
      viol_sticky <= '0;
      viol_cnt    <= '0;
      first_id    <= '0;
      first_valid <= 1'b0;
    end else begin
      viol_sticky <= viol_sticky | viol_pulse;
      if (cnt_sum > {3'b000, {CNTW{1'b1}}}) viol_cnt <= '1;
      else                                  viol_cnt <= cnt_sum[CNTW-1:0];
      if (!first_valid && (|viol_pulse)) begin
        first_id    <= low_id;
        first_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_protocol_checker.sv
// tb_alu_protocol_checker: directed bench for alu_protocol_checker (LAT=1,
// TIMEOUT=16, CNTW=8). Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_alu_protocol_checker;
  import alu_chk_pkg::*;

  localparam int DW = 8, CW = 4, LAT = 1, TIMEOUT = 16, CNTW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en  = 1'b1;
  logic            clr = 1'b0;
  logic [3:0]      viol_pulse, viol_sticky;
  logic [CNTW-1:0] viol_cnt;
  logic [1:0]      first_id;
  logic            first_valid;
  int              errors = 0;
  int              checks = 0;

  alu_protocol_checker_if #(.DW(DW), .CW(CW)) bus ();

  alu_protocol_checker #(.DW(DW), .CW(CW), .LAT(LAT), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr         (clr),
    .bus         (bus),
    .viol_pulse  (viol_pulse),
    .viol_sticky (viol_sticky),
    .viol_cnt    (viol_cnt),
    .first_id    (first_id),
    .first_valid (first_valid)
  );

  always #5 clk = ~clk;

  // Quiet bus: full operands, non-compare ADD, stable result
  task automatic apply_idle();
    bus.inp_valid = 2'b11; bus.mode = 1'b1; bus.cmd = '0; bus.ce = 1'b1;
    bus.res = '0; bus.err = 1'b0; bus.oflow = 1'b0; bus.cout = 1'b0;
    bus.g = 1'b0; bus.l = 1'b0; bus.e = 1'b0;
    clr = 1'b0; en = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b0;
    apply_idle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_idle();
    rst = 1'b0;
    next_cycle(); next_cycle(); sample();
    checks++;
    if ({viol_pulse, viol_sticky, viol_cnt, first_id, first_valid} !== 19'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h required 0", {viol_pulse, viol_sticky, viol_cnt, first_id, first_valid});
    end
    next_cycle(); rst = 1'b1; bus.inp_valid = 2'b00;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL reset_first_cycle: got %b required 0000", viol_pulse); end
    next_cycle(); bus.inp_valid = 2'b11;
    sample();
    checks++;
    if (viol_pulse !== 4'b0001) begin errors++; $display("[TB] FAIL reset_then_inv: got %b required 0001", viol_pulse); end
    next_cycle(); sample();
    checks++;
    if (viol_cnt !== 8'd1 || viol_sticky !== 4'b0001) begin
      errors++; $display("[TB] FAIL reset_then_cnt: got cnt=%0d sticky=%b required 1/0001", viol_cnt, viol_sticky);
    end
    #2; rst = 1'b0; #1;
    checks++;
    if ({viol_pulse, viol_sticky, viol_cnt, first_id, first_valid} !== 19'd0) begin
      errors++; $display("[TB] FAIL async_reset: got %h required 0", {viol_pulse, viol_sticky, viol_cnt, first_id, first_valid});
    end
  endtask

  task automatic test_invalid();
    do_reset();
    next_cycle(); bus.inp_valid = 2'b00;
    next_cycle(); bus.inp_valid = 2'b11; bus.err = 1'b1;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL inv_err_ok: got %b required 0000", viol_pulse); end
    next_cycle(); bus.err = 1'b0; bus.inp_valid = 2'b00;
    next_cycle(); bus.inp_valid = 2'b11;
    sample();
    checks++;
    if (viol_pulse !== 4'b0001) begin errors++; $display("[TB] FAIL inv_pulse: got %b required 0001", viol_pulse); end
    next_cycle(); sample();
    checks++;
    if (viol_sticky !== 4'b0001 || viol_cnt !== 8'd1 || first_valid !== 1'b1 || first_id !== 2'd0) begin
      errors++; $display("[TB] FAIL inv_report: got sticky=%b cnt=%0d fv=%b id=%0d required 0001/1/1/0", viol_sticky, viol_cnt, first_valid, first_id);
    end
    next_cycle(); bus.inp_valid = 2'b00;
    next_cycle(); bus.inp_valid = 2'b11; en = 1'b0;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL en_gate_pulse: got %b required 0000", viol_pulse); end
    next_cycle(); en = 1'b1; sample();
    checks++;
    if (viol_cnt !== 8'd1) begin errors++; $display("[TB] FAIL en_gate_cnt: got %0d required 1", viol_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    next_cycle(); bus.mode = 1'b1; bus.cmd = 4'd0; bus.inp_valid = 2'b01;
    repeat (15) next_cycle();
    next_cycle(); bus.inp_valid = 2'b11;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL to_early: got %b required 0000", viol_pulse); end
    next_cycle(); sample();
    checks++;
    if (viol_pulse !== 4'b0010) begin errors++; $display("[TB] FAIL to_pulse: got %b required 0010", viol_pulse); end
    next_cycle(); sample();
    checks++;
    if (first_id !== 2'd1 || first_valid !== 1'b1 || viol_cnt !== 8'd1) begin
      errors++; $display("[TB] FAIL to_report: got id=%0d fv=%b cnt=%0d required 1/1/1", first_id, first_valid, viol_cnt);
    end
    next_cycle(); bus.inp_valid = 2'b01;
    repeat (15) next_cycle();
    next_cycle(); bus.inp_valid = 2'b00;
    next_cycle(); bus.inp_valid = 2'b11;
    sample();
    checks++;
    if (viol_pulse !== 4'b0010) begin errors++; $display("[TB] FAIL to_inv_single: got %b required 0010", viol_pulse); end
    next_cycle(); sample();
    checks++;
    if (viol_cnt !== 8'd2 || viol_sticky !== 4'b0010) begin
      errors++; $display("[TB] FAIL to_inv_cnt: got cnt=%0d sticky=%b required 2/0010", viol_cnt, viol_sticky);
    end
  endtask

  task automatic test_timeout_freeze();
    logic [3:0] seen;
    do_reset();
    next_cycle(); bus.inp_valid = 2'b01;
    repeat (9) next_cycle();
    seen = 4'b0000;
    repeat (5) begin next_cycle(); bus.ce = 1'b0; sample(); seen |= viol_pulse; end
    repeat (6) begin next_cycle(); bus.ce = 1'b1; sample(); seen |= viol_pulse; end
    next_cycle(); bus.inp_valid = 2'b11; sample(); seen |= viol_pulse;
    checks++;
    if (seen !== 4'b0000) begin errors++; $display("[TB] FAIL freeze_quiet: got %b required 0000", seen); end
    next_cycle(); sample();
    checks++;
    if (viol_pulse !== 4'b0010) begin errors++; $display("[TB] FAIL freeze_expire: got %b required 0010", viol_pulse); end
  endtask

  task automatic test_timeout_restart();
    logic [3:0] seen;
    do_reset();
    next_cycle(); bus.cmd = 4'd0; bus.inp_valid = 2'b01;
    repeat (7) next_cycle();
    next_cycle(); bus.cmd = 4'd1;
    seen = 4'b0000;
    repeat (15) begin next_cycle(); sample(); seen |= viol_pulse; end
    next_cycle(); bus.inp_valid = 2'b11; sample(); seen |= viol_pulse;
    checks++;
    if (seen !== 4'b0000) begin errors++; $display("[TB] FAIL restart_quiet: got %b required 0000", seen); end
    next_cycle(); bus.cmd = 4'd0; sample();
    checks++;
    if (viol_pulse !== 4'b0010) begin errors++; $display("[TB] FAIL restart_expire: got %b required 0010", viol_pulse); end
  endtask

  task automatic test_timeout_complete();
    logic [3:0] seen;
    do_reset();
    next_cycle(); bus.inp_valid = 2'b01;
    repeat (9) next_cycle();
    next_cycle(); bus.inp_valid = 2'b10;
    next_cycle(); bus.inp_valid = 2'b11;
    seen = 4'b0000;
    repeat (25) begin next_cycle(); sample(); seen |= viol_pulse; end
    checks++;
    if (seen !== 4'b0000 || viol_sticky !== 4'b0000) begin
      errors++; $display("[TB] FAIL complete_quiet: got pulses=%b sticky=%b required 0000/0000", seen, viol_sticky);
    end
  endtask

  task automatic test_timeout_reset();
    logic [3:0] seen;
    do_reset();
    next_cycle(); bus.inp_valid = 2'b01;
    repeat (7) next_cycle();
    next_cycle(); rst = 1'b0; bus.inp_valid = 2'b11;
    sample();
    checks++;
    if ({viol_pulse, viol_sticky, viol_cnt, first_id, first_valid} !== 19'd0) begin
      errors++; $display("[TB] FAIL midwin_reset: got %h required 0", {viol_pulse, viol_sticky, viol_cnt, first_id, first_valid});
    end
    next_cycle(); rst = 1'b1;
    seen = 4'b0000;
    repeat (25) begin next_cycle(); sample(); seen |= viol_pulse; end
    checks++;
    if (seen !== 4'b0000 || viol_cnt !== 8'd0) begin
      errors++; $display("[TB] FAIL midwin_abandon: got pulses=%b cnt=%0d required 0000/0", seen, viol_cnt);
    end
  endtask

  task automatic test_cmpflag();
    do_reset();
    next_cycle(); bus.mode = 1'b1; bus.cmd = 4'd8;
    next_cycle(); bus.cmd = 4'd0; bus.e = 1'b1;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL cmp_clean: got %b required 0000", viol_pulse); end
    next_cycle(); bus.cmd = 4'd8; bus.e = 1'b0;
    next_cycle(); bus.cmd = 4'd0; bus.g = 1'b1; bus.e = 1'b1;
    sample();
    checks++;
    if (viol_pulse !== 4'b0100) begin errors++; $display("[TB] FAIL cmp_twohot: got %b required 0100", viol_pulse); end
    next_cycle(); bus.cmd = 4'd8; bus.g = 1'b0; bus.e = 1'b0;
    next_cycle(); bus.cmd = 4'd0; bus.err = 1'b1;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL cmp_err_masks: got %b required 0000", viol_pulse); end
    next_cycle(); bus.cmd = 4'd8; bus.mode = 1'b0; bus.err = 1'b0;
    next_cycle(); bus.cmd = 4'd0; bus.mode = 1'b1;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL cmp_logical: got %b required 0000", viol_pulse); end
  endtask

  task automatic test_multi();
    do_reset();
    next_cycle(); bus.mode = 1'b1; bus.cmd = 4'd8; bus.inp_valid = 2'b00;
    next_cycle(); bus.cmd = 4'd0; bus.inp_valid = 2'b11;
    sample();
    checks++;
    if (viol_pulse !== 4'b0101) begin errors++; $display("[TB] FAIL multi_pulse: got %b required 0101", viol_pulse); end
    next_cycle(); sample();
    checks++;
    if (viol_cnt !== 8'd2 || first_id !== 2'd0 || viol_sticky !== 4'b0101) begin
      errors++; $display("[TB] FAIL multi_report: got cnt=%0d id=%0d sticky=%b required 2/0/0101", viol_cnt, first_id, viol_sticky);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.res = 9'h012;
    next_cycle();
    next_cycle(); bus.ce = 1'b0;
    next_cycle();
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL hold_stable: got %b required 0000", viol_pulse); end
    next_cycle(); bus.res = 9'h013;
    sample();
    checks++;
    if (viol_pulse !== 4'b1000) begin errors++; $display("[TB] FAIL hold_change: got %b required 1000", viol_pulse); end
    next_cycle(); bus.ce = 1'b1;
    sample();
    checks++;
    if (viol_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL hold_release: got %b required 0000", viol_pulse); end
    next_cycle(); sample();
    checks++;
    if (viol_sticky !== 4'b1000 || viol_cnt !== 8'd1 || first_id !== 2'd3) begin
      errors++; $display("[TB] FAIL hold_report: got sticky=%b cnt=%0d id=%0d required 1000/1/3", viol_sticky, viol_cnt, first_id);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    next_cycle(); bus.inp_valid = 2'b00;
    repeat (299) next_cycle();
    next_cycle(); bus.inp_valid = 2'b11;
    next_cycle(); sample();
    checks++;
    if (viol_cnt !== 8'd255 || viol_sticky !== 4'b0001) begin
      errors++; $display("[TB] FAIL sat_cnt: got cnt=%0d sticky=%b required 255/0001", viol_cnt, viol_sticky);
    end
    next_cycle(); bus.inp_valid = 2'b00;
    next_cycle(); bus.inp_valid = 2'b11; clr = 1'b1;
    sample();
    checks++;
    if (viol_pulse !== 4'b0001) begin errors++; $display("[TB] FAIL clr_pulse_present: got %b required 0001", viol_pulse); end
    next_cycle(); clr = 1'b0; sample();
    checks++;
    if (viol_cnt !== 8'd0 || viol_sticky !== 4'b0000 || first_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_result: got cnt=%0d sticky=%b fv=%b required 0/0000/0", viol_cnt, viol_sticky, first_valid);
    end
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_timeout();
    test_timeout_freeze();
    test_timeout_restart();
    test_timeout_complete();
    test_timeout_reset();
    test_cmpflag();
    test_multi();
    test_hold();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_protocol_checker.md
Name: alu_protocol_checker

Overview:
- Synthesizable, parametrised protocol and flag checker that sits beside the ALU DUT and monitors its input bus and registered outputs.
- Replaces the single-property invalid-input assertion with four latency-aware checks:
  - invalid-input error
  - split-operand timeout
  - compare-flag one-hot
  - output hold while ce is low
- Reports sticky per-check flags, per-cycle pulses, a saturating violation count and the first-failure ID.
- Usable in simulation and emulation; no SVA required.

Parameters:
- DW, 8, operand width; res is DW+1 bits.
- CW, 4, cmd width.
- LAT, 1, ALU output latency in cycles (≥1).
- TIMEOUT, 16, ce-qualified cycles allowed for the missing operand to arrive.
- CNTW, 8, width of the violation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  check enable; when 0, no violations are recorded, but the pipeline and FSM keep tracking.
- clr  in  1  synchronous clear of sticky, count and first-failure fields.
- inp_valid  in  2  ALU operand-valid bits {b,a}.
- mode  in  1  1 = arithmetic, 0 = logical.
- cmd  in  CW  ALU command.
- ce  in  1  ALU clock enable.
- res  in  DW+1  ALU result.
- err, oflow, cout, g, l, e  in  1 each  ALU flags.
- viol_pulse  out  4  per-check violation in this cycle.
- viol_sticky  out  4  per-check latched violation.
- viol_cnt  out  CNTW  saturating total violation count.
- first_id  out  2  ID of the first violation since reset or clr.
- first_valid  out  1  first_id is meaningful.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM in IDLE; timeout counter 0; expectation pipeline valid bits 0. A reset mid-window abandons the window.
- Expectation pipeline: LAT-deep shift of {valid, exp_err, is_cmp, ce}. Stage 0 is loaded every cycle; valid is set to 1 one cycle after reset deassertion. Checks fire only on valid outputs of the last stage, so no check fires in the first LAT cycles after reset.
- C0 INVALID (id 0): ce=1 and inp_valid=00 at cycle t → err must be 1 at t+LAT.
- C1 TIMEOUT (id 1), FSM {IDLE, WAIT}:
  - IDLE→WAIT when ce=1, is_two_op(mode,cmd), and inp_valid ∈ {01,10}. Latch the present bit, mode and cmd; cnt=1.
  - In WAIT, on ce=1 cycles:
    - inp_valid=11, or the complement bit arrives → IDLE, check satisfied.
    - mode/cmd differ from latched → restart: re-latch, cnt=1 if still partial and two-op, else IDLE.
    - Otherwise cnt++.
  - cnt==TIMEOUT → inject exp_err into stage 0 and go to IDLE. Err must be 1 LAT cycles later.
  - ce=0 freezes cnt and state.
  - Timeout and inp_valid=00 in the same cycle → a single exp_err, reported once, as C1.
- C2 CMPFLAG (id 2): stage-0 is_cmp = (mode=1 and cmd=CMD_CMP) and ce=1. At the last stage, if err=0, {g,l,e} must be exactly one-hot.
- C3 HOLD (id 3): last-stage ce=0 → res must equal res of the previous cycle. Compared against a registered copy of res.
- Reporting (only when en=1):
  - viol_pulse is combinational from the checks.
  - viol_sticky |= viol_pulse on the next edge.
  - viol_cnt += popcount(viol_pulse), saturating at all-ones.
  - first_id is latched on the first cycle with any pulse while first_valid=0; if several checks fire together, the lowest ID wins.
  - clr=1 zeroes sticky, cnt and first_valid that cycle. A pulse in the same cycle as clr is dropped.

Decomposition:
- Shared package alu_chk_pkg holds:
  - enum chk_id_e {CHK_INVALID=0, CHK_TIMEOUT=1, CHK_CMPFLAG=2, CHK_HOLD=3}
  - constant CMD_CMP = 4'd8
  - function is_two_op(mode, cmd):
    - arithmetic mode: cmd ∈ {0,1,2,3,8,9,10}
    - logical mode: cmd ∈ {0,1,2,3,4,5,12,13}
  - FSM state enum {IDLE, WAIT}
- One natural sub-module: alu_chk_timeout, containing the WAIT FSM and counter and emitting a one-cycle exp_err strobe.

Test Plan:
- ce=1, inp_valid=00, cmd=0, mode=1; DUT err=1 at t+1 → no pulse. Repeat with err=0 → viol_pulse=0001 at t+1, sticky=0001, cnt=1, first_id=0.
- Two-op ADD with inp_valid=01 held for 16 ce cycles; err=0 at t+16+1 → viol_pulse=0010, first_id=1.
- Same window, but inp_valid=10 arrives at cycle 10 → IDLE, no violation. Assert rst at cycle 8 instead → no violation, all outputs 0.
- CMP (mode=1, cmd=8, opa=5, opb=5) with g=0, l=0, e=1 → clean. Same stimulus with g=1, e=1 → viol_pulse=0100.
- ce=0 for 3 cycles while res changes 0x12→0x13 → viol_pulse=1000. With C0 firing in the same cycle → cnt += 2, first_id=0.
- Drive 300 C0 violations with CNTW=8 → viol_cnt saturates at 255. Pulse clr → cnt=0, sticky=0, first_valid=0.
